// File: rtl/full_adder_pkg.sv
// rtl/full_adder_pkg.sv - shared width and reset constants for the 4-bit adder slice
package full_adder_pkg;

  localparam int FA4_W = 4;
  localparam logic [FA4_W-1:0] FA4_SUM_RST = 4'b0000;

endpackage

// File: rtl/full_adder_1b.sv
// rtl/full_adder_1b.sv - combinational 1-bit full-adder cell
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder_4b.sv
// rtl/full_adder_4b.sv - registered 4-bit ripple-carry adder; FULL_ADDER_4B_OVF_EN adds the ovf output
module full_adder_4b
  import full_adder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [FA4_W-1:0] a,
  input  logic [FA4_W-1:0] b,
  input  logic             cin,
  output logic [FA4_W-1:0] sum,
`ifdef FULL_ADDER_4B_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  // c[i] is the carry into stage i; c[FA4_W] is the carry out of the MSB
  logic [FA4_W:0]   c;
  logic [FA4_W-1:0] s;

  assign c[0] = cin;

  full_adder_1b u_fa0 (.a(a[0]), .b(b[0]), .cin(c[0]), .sum(s[0]), .cout(c[1]));
  full_adder_1b u_fa1 (.a(a[1]), .b(b[1]), .cin(c[1]), .sum(s[1]), .cout(c[2]));
  full_adder_1b u_fa2 (.a(a[2]), .b(b[2]), .cin(c[2]), .sum(s[2]), .cout(c[3]));
  full_adder_1b u_fa3 (.a(a[3]), .b(b[3]), .cin(c[3]), .sum(s[3]), .cout(c[4]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= FA4_SUM_RST;
      cout <= 1'b0;
`ifdef FULL_ADDER_4B_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      sum  <= s;
      cout <= c[FA4_W];
`ifdef FULL_ADDER_4B_OVF_EN
      // signed overflow: carry into the sign bit differs from carry out of it
      ovf  <= c[FA4_W] ^ c[FA4_W-1];
`endif
    end
  end

endmodule

// File: tb/tb_full_adder_4b.sv
// tb/tb_full_adder_4b.sv - directed self-checking bench for full_adder_4b (FULL_ADDER_4B_OVF_EN aware)
module tb_full_adder_4b;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] sum;
  logic       cout;
`ifdef FULL_ADDER_4B_OVF_EN
  logic       ovf;
`endif

  int compared;
  int mismatched;

  full_adder_4b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
`ifdef FULL_ADDER_4B_OVF_EN
    .cout  (cout),
    .ovf   (ovf)
`else
    .cout  (cout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    a = 4'h5;
    b = 4'h3;
    cin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      compared++;
      if (sum !== 4'b0000) begin
        mismatched++;
        $display("FAIL reset_sum cycle %0d got %b want 0000", i, sum);
      end
      compared++;
      if (cout !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_cout cycle %0d got %b want 0", i, cout);
      end
`ifdef FULL_ADDER_4B_OVF_EN
      compared++;
      if (ovf !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_ovf cycle %0d got %b want 0", i, ovf);
      end
`endif
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if (sum !== 4'b1001) begin
      mismatched++;
      $display("FAIL reset_release_sum got %b want 1001", sum);
    end
    compared++;
    if (cout !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release_cout got %b want 0", cout);
    end
  endtask

  task automatic test_low_sweep();
    logic [3:0] exp_sum [4];
    exp_sum[0] = 4'b0000;
    exp_sum[1] = 4'b0001;
    exp_sum[2] = 4'b0010;
    exp_sum[3] = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 4'h0;
      b = 4'(i);
      cin = 1'b0;
      @(posedge clk);
      #1;
      compared++;
      if (sum !== exp_sum[i]) begin
        mismatched++;
        $display("FAIL low_sweep_sum b=%0d got %b want %b", i, sum, exp_sum[i]);
      end
      compared++;
      if (cout !== 1'b0) begin
        mismatched++;
        $display("FAIL low_sweep_cout b=%0d got %b want 0", i, cout);
      end
    end
  endtask

  task automatic test_cin_sweep();
    logic [3:0] exp_sum [4];
    exp_sum[0] = 4'b0101;
    exp_sum[1] = 4'b0110;
    exp_sum[2] = 4'b0111;
    exp_sum[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 4'h0;
      b = 4'(i + 4);
      cin = 1'b1;
      @(posedge clk);
      #1;
      compared++;
      if (sum !== exp_sum[i]) begin
        mismatched++;
        $display("FAIL cin_sweep_sum b=%0d got %b want %b", i + 4, sum, exp_sum[i]);
      end
      compared++;
      if (cout !== 1'b0) begin
        mismatched++;
        $display("FAIL cin_sweep_cout b=%0d got %b want 0", i + 4, cout);
      end
    end
  endtask

  task automatic test_full_ripple();
    @(negedge clk);
    a = 4'hF;
    b = 4'h0;
    cin = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if (sum !== 4'b0000 || cout !== 1'b1) begin
      mismatched++;
      $display("FAIL full_ripple got cout=%b sum=%b want cout=1 sum=0000", cout, sum);
    end
`ifdef FULL_ADDER_4B_OVF_EN
    compared++;
    if (ovf !== 1'b0) begin
      mismatched++;
      $display("FAIL full_ripple_ovf got %b want 0", ovf);
    end
`endif
    @(negedge clk);
    a = 4'hF;
    b = 4'hF;
    cin = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if (sum !== 4'b1111 || cout !== 1'b1) begin
      mismatched++;
      $display("FAIL max_result got cout=%b sum=%b want cout=1 sum=1111", cout, sum);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    a = 4'h1;
    b = 4'h1;
    cin = 1'b0;
    @(posedge clk);
    #1;
    compared++;
    if (sum !== 4'b0010 || cout !== 1'b0) begin
      mismatched++;
      $display("FAIL latency_first got cout=%b sum=%b want cout=0 sum=0010", cout, sum);
    end
    #2;
    a = 4'h4;
    b = 4'hC;
    #1;
    compared++;
    if (sum !== 4'b0010 || cout !== 1'b0) begin
      mismatched++;
      $display("FAIL latency_hold got cout=%b sum=%b want cout=0 sum=0010", cout, sum);
    end
    @(posedge clk);
    #1;
    compared++;
    if (sum !== 4'b0000 || cout !== 1'b1) begin
      mismatched++;
      $display("FAIL latency_update got cout=%b sum=%b want cout=1 sum=0000", cout, sum);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a = 4'hF;
    b = 4'hF;
    cin = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (sum !== 4'b0000 || cout !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset_immediate got cout=%b sum=%b want cout=0 sum=0000", cout, sum);
    end
    @(posedge clk);
    #1;
    compared++;
    if (sum !== 4'b0000 || cout !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset_hold got cout=%b sum=%b want cout=0 sum=0000", cout, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a = 4'h2;
    b = 4'h3;
    cin = 1'b0;
    #2;
    compared++;
    if (sum !== 4'b0000 || cout !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset_no_pending got cout=%b sum=%b want cout=0 sum=0000", cout, sum);
    end
    @(posedge clk);
    #1;
    compared++;
    if (sum !== 4'b0101 || cout !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset_resume got cout=%b sum=%b want cout=0 sum=0101", cout, sum);
    end
  endtask

`ifdef FULL_ADDER_4B_OVF_EN
  task automatic test_ovf();
    logic [3:0] va   [3];
    logic [3:0] vb   [3];
    logic [3:0] esum [3];
    logic       ecout[3];
    logic       eovf [3];
    va[0] = 4'h7; vb[0] = 4'h1; esum[0] = 4'b1000; ecout[0] = 1'b0; eovf[0] = 1'b1;
    va[1] = 4'h8; vb[1] = 4'h8; esum[1] = 4'b0000; ecout[1] = 1'b1; eovf[1] = 1'b1;
    va[2] = 4'h3; vb[2] = 4'h2; esum[2] = 4'b0101; ecout[2] = 1'b0; eovf[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = va[i];
      b = vb[i];
      cin = 1'b0;
      @(posedge clk);
      #1;
      compared++;
      if (sum !== esum[i] || cout !== ecout[i]) begin
        mismatched++;
        $display("FAIL ovf_vec%0d got cout=%b sum=%b want cout=%b sum=%b", i, cout, sum, ecout[i], esum[i]);
      end
      compared++;
      if (ovf !== eovf[i]) begin
        mismatched++;
        $display("FAIL ovf_flag%0d got %b want %b", i, ovf, eovf[i]);
      end
    end
  endtask
`endif

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_low_sweep();
    test_cin_sweep();
    test_full_ripple();
    test_latency();
    test_async_reset();
`ifdef FULL_ADDER_4B_OVF_EN
    test_ovf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
